atp_payment_ctrl: RTL and testbench

//  Next-generation controller for the any-time electricity bill payment (ATP) kiosk.

---
 rtl/atp_payment_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_atp_payment_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/atp_payment_ctrl.sv
// ATP kiosk payment controller: bill capture, cash/UPI payment, change, refund and receipt.
// Optional card payment path is compiled in when ATP_CARD_PAY_EN is defined.
module atp_payment_ctrl #(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned NOTE_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              place_bill,
  input  logic              scan_valid,
  input  logic [AMT_W-1:0]  scan_amount,
  input  logic              sel_cash,
  input  logic              sel_upi,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_value,
  input  logic              upi_ok,
  input  logic              upi_fail,
  input  logic              cancel,
  input  logic              printer_ack,
  input  logic              refund_ack,
`ifdef ATP_CARD_PAY_EN
  input  logic              sel_card,
  input  logic              card_ok,
  input  logic              card_fail,
  output logic              card_prompt,
`endif
  output logic              accept_cash,
  output logic              display_qr,
  output logic              display_amount,
  output logic              display_instructions,
  output logic              complete_txn,
  output logic              print_receipt,
  output logic [AMT_W-1:0]  change_amount,
  output logic              refund_valid,
  output logic [AMT_W-1:0]  refund_amount,
  output logic [AMT_W-1:0]  paid_total,
  output logic              busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TimerLoad = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StScan   = 4'd1,
    StSelect = 4'd2,
    StCash   = 4'd3,
    StUpi    = 4'd4,
    StDone   = 4'd5,
    StPrint  = 4'd6,
`ifdef ATP_CARD_PAY_EN
    StRefund = 4'd7,
    StCard   = 4'd8
`else
    StRefund = 4'd7
`endif
  } state_t;

  state_t           state, stateN, abortTo;
  logic [AMT_W-1:0] billAmt, billN, paidN, changeN, noteTotal;
  logic [AMT_W:0]   noteSum;
  logic [TW-1:0]    timer, timerN;
  logic [RW-1:0]    retryCnt, retryN;
  logic             payOk, payFail;

  always_comb begin
    stateN  = state;
    billN   = billAmt;
    paidN   = paid_total;
    timerN  = timer;
    retryN  = retryCnt;
    changeN = change_amount;

    noteSum   = {1'b0, paid_total} + {1'b0, AMT_W'(note_value)};
    noteTotal = noteSum[AMT_W] ? '1 : noteSum[AMT_W-1:0];
    abortTo   = (paid_total != '0) ? StRefund : StIdle;

`ifdef ATP_CARD_PAY_EN
    payOk   = (state == StCard) ? card_ok : upi_ok;
    payFail = (state == StCard) ? card_fail : upi_fail;
`else
    payOk   = upi_ok;
    payFail = upi_fail;
`endif

    case (state)
      StIdle: if (place_bill) stateN = StScan;
      StScan: begin
        if (scan_valid) begin
          billN = scan_amount;
          if (scan_amount == '0) begin
            stateN  = StDone;
            changeN = '0;
          end else begin
            stateN = StSelect;
            timerN = TimerLoad;
          end
        end
      end
      StSelect: begin
        if (cancel) begin
          stateN = abortTo;
        end else if (sel_cash) begin
          stateN = StCash;
          timerN = TimerLoad;
        end else if (sel_upi) begin
          stateN = StUpi;
          timerN = TimerLoad;
`ifdef ATP_CARD_PAY_EN
        end else if (sel_card) begin
          stateN = StCard;
          timerN = TimerLoad;
`endif
        end else if (timer == '0) begin
          stateN = abortTo;
        end else begin
          timerN = timer - 1'b1;
        end
      end
      StCash: begin
        if (note_valid) paidN = noteTotal;
        // A note arriving with cancel is banked before the refund is decided.
        if (cancel) begin
          stateN = (paidN != '0) ? StRefund : StIdle;
        end else if (note_valid) begin
          timerN = TimerLoad;
          if (noteTotal >= billAmt) begin
            stateN  = StDone;
            changeN = noteTotal - billAmt;
          end
        end else if (timer == '0) begin
          stateN = abortTo;
        end else begin
          timerN = timer - 1'b1;
        end
      end
`ifdef ATP_CARD_PAY_EN
      StUpi, StCard: begin
`else
      StUpi: begin
`endif
        if (payOk) begin
          stateN  = StDone;
          changeN = '0;
        end else if (cancel) begin
          stateN = abortTo;
        end else if (payFail) begin
          retryN = retryCnt + 1'b1;
          timerN = TimerLoad;
          if (retryN == RW'(MAX_RETRY)) stateN = StIdle;
        end else if (timer == '0) begin
          stateN = abortTo;
        end else begin
          timerN = timer - 1'b1;
        end
      end
      StDone:  stateN = StPrint;
      StPrint: if (printer_ack) stateN = StIdle;
      StRefund: begin
        if (refund_ack) stateN = StIdle;
      end
      default: stateN = StIdle;
    endcase

    // Every return to idle starts the next transaction from a clean slate.
    if (stateN == StIdle) begin
      paidN   = '0;
      changeN = '0;
      retryN  = '0;
      billN   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= StIdle;
      billAmt              <= '0;
      timer                <= '0;
      retryCnt             <= '0;
      paid_total           <= '0;
      change_amount        <= '0;
      refund_amount        <= '0;
      accept_cash          <= 1'b0;
      display_qr           <= 1'b0;
      display_amount       <= 1'b0;
      display_instructions <= 1'b0;
      complete_txn         <= 1'b0;
      print_receipt        <= 1'b0;
      refund_valid         <= 1'b0;
      busy                 <= 1'b0;
`ifdef ATP_CARD_PAY_EN
      card_prompt          <= 1'b0;
`endif
    end else begin
      state                <= stateN;
      billAmt              <= billN;
      timer                <= timerN;
      retryCnt             <= retryN;
      paid_total           <= paidN;
      change_amount        <= changeN;
      refund_amount        <= (stateN == StRefund) ? paidN : '0;
      accept_cash          <= (stateN == StCash);
      display_qr           <= (stateN == StUpi);
`ifdef ATP_CARD_PAY_EN
      display_amount       <= (stateN == StSelect) || (stateN == StCash) ||
                              (stateN == StUpi) || (stateN == StCard);
      card_prompt          <= (stateN == StCard);
`else
      display_amount       <= (stateN == StSelect) || (stateN == StCash) || (stateN == StUpi);
`endif
      display_instructions <= (stateN == StSelect);
      complete_txn         <= (stateN == StDone);
      print_receipt        <= (stateN == StPrint);
      refund_valid         <= (stateN == StRefund);
      busy                 <= (stateN != StIdle);
    end
  end

endmodule

// File: tb/tb_atp_payment_ctrl.sv
// Directed bench for atp_payment_ctrl with a change/refund scoreboard (TIMEOUT_CYC=10, MAX_RETRY=3).
module tb_atp_payment_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        place_bill = 0, scan_valid = 0, sel_cash = 0, sel_upi = 0, note_valid = 0;
  logic        upi_ok = 0, upi_fail = 0, cancel = 0, printer_ack = 0, refund_ack = 0;
  logic [15:0] scan_amount = '0;
  logic [7:0]  note_value = '0;
  logic        accept_cash, display_qr, display_amount, display_instructions;
  logic        complete_txn, print_receipt, refund_valid, busy;
  logic [15:0] change_amount, refund_amount, paid_total;
`ifdef ATP_CARD_PAY_EN
  logic        sel_card = 0, card_ok = 0, card_fail = 0, card_prompt;
`endif

  int nAssert = 0;
  int nFail = 0;
  logic [15:0] changeQ[$];
  logic [15:0] refundQ[$];

  always #5 clk = ~clk;

  atp_payment_ctrl #(
    .AMT_W(16), .NOTE_W(8), .TIMEOUT_CYC(10), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .place_bill(place_bill), .scan_valid(scan_valid),
    .scan_amount(scan_amount), .sel_cash(sel_cash), .sel_upi(sel_upi),
    .note_valid(note_valid), .note_value(note_value), .upi_ok(upi_ok), .upi_fail(upi_fail),
    .cancel(cancel), .printer_ack(printer_ack), .refund_ack(refund_ack),
`ifdef ATP_CARD_PAY_EN
    .sel_card(sel_card), .card_ok(card_ok), .card_fail(card_fail), .card_prompt(card_prompt),
`endif
    .accept_cash(accept_cash), .display_qr(display_qr), .display_amount(display_amount),
    .display_instructions(display_instructions), .complete_txn(complete_txn),
    .print_receipt(print_receipt), .change_amount(change_amount), .refund_valid(refund_valid),
    .refund_amount(refund_amount), .paid_total(paid_total), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic startTxn(input logic [15:0] amt);
    place_bill = 1; tick(); place_bill = 0;
    scan_valid = 1; scan_amount = amt; tick(); scan_valid = 0;
  endtask

  task automatic note(input logic [7:0] v, input logic withCancel);
    note_valid = 1; note_value = v; cancel = withCancel; tick();
    note_valid = 0; cancel = 0;
  endtask

  task automatic popChange(input string tag);
    logic [15:0] e;
    if (changeQ.size() == 0) begin
      nAssert++; nFail++;
      $error("FAIL %s: observed empty change queue, expected an entry", tag);
    end else begin
      e = changeQ.pop_front();
      check(tag, 32'(change_amount), 32'(e));
    end
  endtask

  task automatic popRefund(input string tag);
    logic [15:0] e;
    if (refundQ.size() == 0) begin
      nAssert++; nFail++;
      $error("FAIL %s: observed empty refund queue, expected an entry", tag);
    end else begin
      e = refundQ.pop_front();
      check(tag, 32'(refund_amount), 32'(e));
    end
  endtask

  // Counts clock ticks until busy drops, giving up after budget.
  task automatic waitIdle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
  endtask

  task automatic waitRefund(input int budget, output int n);
    n = 0;
    while (!refund_valid && n < budget) begin tick(); n++; end
  endtask

  function automatic logic [7:0] ctlBits();
    return {accept_cash, display_qr, display_amount, display_instructions,
            complete_txn, print_receipt, refund_valid, busy};
  endfunction

  initial begin
    int n;
    repeat (2) tick();
    check("reset_ctl", 32'(ctlBits()), 32'd0);
    check("reset_amts", {paid_total, change_amount | refund_amount}, 32'd0);
    reset = 1;
    tick();

    // Cash, overpay with change.
    startTxn(16'd150);
    check("sel_display", 32'({display_instructions, display_amount, busy}), 32'b111);
    sel_cash = 1; tick(); sel_cash = 0;
    check("cash_enter", 32'({accept_cash, display_instructions}), 32'b10);
    changeQ.push_back(16'd50);
    note(8'd100, 0);
    check("paid_100", 32'(paid_total), 32'd100);
    note(8'd100, 0);
    check("done_pulse", 32'(complete_txn), 32'd1);
    popChange("change_50");
    tick();
    check("pulse_end", 32'({complete_txn, print_receipt}), 32'b01);
    tick();
    check("print_hold", 32'({print_receipt, 16'(change_amount)}), {15'd0, 1'b1, 16'd50});
    printer_ack = 1; tick(); printer_ack = 0;
    check("print_idle", 32'({busy, print_receipt, 16'(change_amount)}), 32'd0);

    // Cash, partial then cancel.
    startTxn(16'd200);
    sel_cash = 1; tick(); sel_cash = 0;
    note(8'd100, 0);
    refundQ.push_back(16'd100);
    cancel = 1; tick(); cancel = 0;
    check("refund_valid", 32'(refund_valid), 32'd1);
    popRefund("refund_100");
    tick();
    check("refund_hold", 32'({refund_valid, busy}), 32'b11);
    refund_ack = 1; tick(); refund_ack = 0;
    check("refund_idle", 32'({busy, refund_valid, 16'(paid_total)}), 32'd0);

    // Note arriving with cancel is counted and refunded.
    startTxn(16'd500);
    sel_cash = 1; tick(); sel_cash = 0;
    note(8'd100, 0);
    refundQ.push_back(16'd130);
    note(8'd30, 1);
    check("note_cancel_rv", 32'(refund_valid), 32'd1);
    popRefund("note_cancel_amt");
    refund_ack = 1; tick(); refund_ack = 0;

    // Cash timeout with partial payment refunds.
    startTxn(16'd300);
    sel_cash = 1; tick(); sel_cash = 0;
    note(8'd20, 0);
    refundQ.push_back(16'd20);
    waitRefund(20, n);
    check("cash_timeout_cyc", 32'(n), 32'd10);
    popRefund("cash_timeout_amt");
    refund_ack = 1; tick(); refund_ack = 0;

    // UPI timeout with nothing paid.
    startTxn(16'd120);
    sel_cash = 1; sel_upi = 1; tick(); sel_cash = 0; sel_upi = 0;
    check("cash_wins", 32'({accept_cash, display_qr}), 32'b10);
    cancel = 1; tick(); cancel = 0;
    check("cancel_nopay", 32'({busy, refund_valid}), 32'b00);
    startTxn(16'd120);
    sel_upi = 1; tick(); sel_upi = 0;
    check("upi_enter", 32'({display_qr, accept_cash, display_amount}), 32'b101);
    waitIdle(20, n);
    check("upi_timeout_cyc", 32'(n), 32'd10);
    check("upi_timeout_norefund", 32'(refund_valid), 32'd0);

    // UPI retries then success.
    startTxn(16'd80);
    sel_upi = 1; tick(); sel_upi = 0;
    repeat (2) begin upi_fail = 1; tick(); upi_fail = 0; end
    check("upi_retry_stay", 32'({display_qr, busy}), 32'b11);
    changeQ.push_back(16'd0);
    upi_ok = 1; upi_fail = 1; tick(); upi_ok = 0; upi_fail = 0;
    check("upi_ok_done", 32'(complete_txn), 32'd1);
    popChange("upi_change");
    tick();
    printer_ack = 1; tick(); printer_ack = 0;
    check("upi_print_idle", 32'(busy), 32'd0);

    // UPI retry exhaustion; counter must start fresh for this transaction.
    startTxn(16'd80);
    sel_upi = 1; tick(); sel_upi = 0;
    repeat (2) begin upi_fail = 1; tick(); upi_fail = 0; end
    check("upi_fail2_busy", 32'(busy), 32'd1);
    upi_fail = 1; tick(); upi_fail = 0;
    check("upi_fail3_idle", 32'({busy, refund_valid}), 32'b00);

    // Zero bill skips selection.
    changeQ.push_back(16'd0);
    startTxn(16'd0);
    check("zero_done", 32'({complete_txn, display_instructions}), 32'b10);
    popChange("zero_change");
    tick();
    check("zero_print", 32'(print_receipt), 32'd1);
    printer_ack = 1; tick(); printer_ack = 0;

    // Reset mid-cash drops the transaction without refund.
    startTxn(16'd200);
    sel_cash = 1; tick(); sel_cash = 0;
    note(8'd50, 0);
    check("pre_reset_paid", 32'(paid_total), 32'd50);
    reset = 0; tick(); reset = 1;
    check("mid_reset_ctl", 32'(ctlBits()), 32'd0);
    check("mid_reset_amts", {paid_total, refund_amount}, 32'd0);

    check("queues_drained", 32'(changeQ.size() + refundQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
